// File: rtl/c1908_fo_ecc_if.sv
// rtl/c1908_fo_ecc_if.sv - signal bundle for the registered SEC/DED Hamming codec
interface c1908_fo_ecc_if;
  logic [15:0] din;
  logic [5:0]  chk;
  logic        in_valid;
  logic        corr_en;
  logic        gen_mode;
  logic        odd_par;
  logic        inj_en;
  logic [4:0]  inj_pos;
  logic        inj_dbl;
  logic [15:0] dout;
  logic [5:0]  syn;
  logic        sec;
  logic        ded;
  logic        out_valid;

  modport master (
    output din, chk, in_valid, corr_en, gen_mode, odd_par, inj_en, inj_pos, inj_dbl,
    input  dout, syn, sec, ded, out_valid
  );

  modport slave (
    input  din, chk, in_valid, corr_en, gen_mode, odd_par, inj_en, inj_pos, inj_dbl,
    output dout, syn, sec, ded, out_valid
  );
endinterface

// File: rtl/c1908_fo_ecc.sv
// rtl/c1908_fo_ecc.sv - registered 16-bit SEC/DED Hamming decoder/encoder with fault injection
module c1908_fo_ecc (
  input  logic             clk,
  input  logic             rst,
  c1908_fo_ecc_if.slave    bus
);

  // Hamming position of each data bit d[0..15]; powers of two hold check bits.
  localparam logic [4:0] DPOS [16] = '{
    5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11, 5'd12,
    5'd13, 5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21
  };

  logic [21:0] cw;
  logic [21:0] flip;
  logic [21:0] rcw;
  logic [21:0] ccw;
  logic [4:0]  s_low;
  logic        s5;
  logic [5:0]  g;
  logic [4:0]  dbl_pos;
  logic        p_in_range;
  logic        p_is_data;
  logic [15:0] nx_dout;
  logic [5:0]  nx_syn;
  logic        nx_sec;
  logic        nx_ded;

  always_comb begin
    cw       = '0;
    cw[0]    = bus.chk[5];
    cw[1]    = bus.chk[0];
    cw[2]    = bus.chk[1];
    cw[4]    = bus.chk[2];
    cw[8]    = bus.chk[3];
    cw[16]   = bus.chk[4];
    for (int i = 0; i < 16; i++) begin
      cw[DPOS[i]] = bus.din[i];
    end

    // Second flip wraps from index 21 back to the overall-parity bit at index 0.
    dbl_pos = (bus.inj_pos == 5'd21) ? 5'd0 : 5'(bus.inj_pos + 5'd1);
    flip    = '0;
    if (bus.inj_en && (bus.inj_pos <= 5'd21)) begin
      flip[bus.inj_pos] = 1'b1;
      if (bus.inj_dbl) begin
        flip[dbl_pos] = 1'b1;
      end
    end
    rcw = cw ^ flip;

    s_low = '0;
    for (int p = 1; p < 22; p++) begin
      for (int k = 0; k < 5; k++) begin
        if (p[k]) begin
          s_low[k] = s_low[k] ^ rcw[p];
        end
      end
    end
    s5 = (^rcw) ^ bus.odd_par;

    g = '0;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 5; k++) begin
        if (DPOS[i][k]) begin
          g[k] = g[k] ^ bus.din[i];
        end
      end
    end
    g[5] = (^bus.din) ^ (^g[4:0]) ^ bus.odd_par;

    p_in_range = (s_low <= 5'd21);
    p_is_data  = p_in_range && (s_low != 5'd0) && ((s_low & 5'(s_low - 5'd1)) != 5'd0);

    ccw = rcw;
    if (s5 && p_is_data && bus.corr_en) begin
      ccw[s_low] = ~rcw[s_low];
    end

    nx_dout = '0;
    for (int i = 0; i < 16; i++) begin
      nx_dout[i] = ccw[DPOS[i]];
    end
    nx_syn = {s5, s_low};
    nx_sec = s5 && p_in_range;
    nx_ded = (s5 && !p_in_range) || (!s5 && (s_low != 5'd0));

    if (bus.gen_mode) begin
      nx_dout = bus.din;
      nx_syn  = g;
      nx_sec  = 1'b0;
      nx_ded  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.dout      <= '0;
      bus.syn       <= '0;
      bus.sec       <= 1'b0;
      bus.ded       <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.dout <= nx_dout;
        bus.syn  <= nx_syn;
        bus.sec  <= nx_sec;
        bus.ded  <= nx_ded;
      end
    end
  end

endmodule

// File: tb/tb_c1908_fo_ecc.sv
// tb/tb_c1908_fo_ecc.sv - scoreboard bench for c1908_fo_ecc with directed vectors
module tb_c1908_fo_ecc;

  typedef struct {
    logic [15:0] dout;
    logic [5:0]  syn;
    logic        sec;
    logic        ded;
  } exp_t;

  logic clk;
  logic rst;
  c1908_fo_ecc_if bus ();

  c1908_fo_ecc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  exp_t last;
  int   n_cmp;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic apply(input logic [15:0] d, input logic [5:0] c, input logic ce,
                       input logic gm, input logic op, input logic ie,
                       input logic [4:0] ip, input logic idb,
                       input logic [15:0] e_dout, input logic [5:0] e_syn,
                       input logic e_sec, input logic e_ded);
    exp_t e;
    @(negedge clk);
    bus.din      = d;
    bus.chk      = c;
    bus.corr_en  = ce;
    bus.gen_mode = gm;
    bus.odd_par  = op;
    bus.inj_en   = ie;
    bus.inj_pos  = ip;
    bus.inj_dbl  = idb;
    bus.in_valid = 1'b1;
    e.dout = e_dout;
    e.syn  = e_syn;
    e.sec  = e_sec;
    e.ded  = e_ded;
    sb.push_back(e);
    last = e;
  endtask

  task automatic check_outputs(input string tag, input exp_t e, input logic ov);
    cmp({tag, ".dout"},      32'(bus.dout),      32'(e.dout));
    cmp({tag, ".syn"},       32'(bus.syn),       32'(e.syn));
    cmp({tag, ".sec"},       32'(bus.sec),       32'(e.sec));
    cmp({tag, ".ded"},       32'(bus.ded),       32'(e.ded));
    cmp({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
  endtask

  // Monitor: every presented result is matched against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && bus.out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got dout=0x%0h with no pending expectation", bus.dout);
        end else begin
          e = sb.pop_front();
          cmp("mon.dout", 32'(bus.dout), 32'(e.dout));
          cmp("mon.syn",  32'(bus.syn),  32'(e.syn));
          cmp("mon.sec",  32'(bus.sec),  32'(e.sec));
          cmp("mon.ded",  32'(bus.ded),  32'(e.ded));
        end
      end
    end
  end

  initial begin
    exp_t zero;
    n_cmp = 0;
    n_bad = 0;
    zero.dout = '0;
    zero.syn  = '0;
    zero.sec  = 1'b0;
    zero.ded  = 1'b0;
    rst = 1'b1;
    bus.din = '0; bus.chk = '0; bus.in_valid = 1'b0; bus.corr_en = 1'b0;
    bus.gen_mode = 1'b0; bus.odd_par = 1'b0; bus.inj_en = 1'b0;
    bus.inj_pos = '0; bus.inj_dbl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Overall-parity error under odd convention gives nonzero state before mid-stream reset
    apply(16'h0000, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 16'h0000, 6'h20, 1'b1, 1'b0);

    @(negedge clk);
    bus.din = 16'hFFFF; bus.chk = 6'h3F; bus.odd_par = 1'b0; bus.in_valid = 1'b1;
    #2 rst = 1'b1;
    #1 check_outputs("midreset", zero, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;

    apply(16'h0000, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 16'h0000, 6'h00, 1'b0, 1'b0);
    apply(16'h0000, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3,  1'b0, 16'h0000, 6'h23, 1'b1, 1'b0);
    apply(16'h0000, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  1'b0, 16'h0001, 6'h23, 1'b1, 1'b0);
    apply(16'h0000, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3,  1'b1, 16'h0001, 6'h07, 1'b0, 1'b1);
    apply(16'h0001, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 16'h0001, 6'h23, 1'b0, 1'b0);
    apply(16'h0001, 6'h23, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 16'h0001, 6'h00, 1'b0, 1'b0);
    apply(16'h0000, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd21, 1'b1, 16'h8000, 6'h15, 1'b0, 1'b1);
    apply(16'h0000, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd16, 1'b0, 16'h0000, 6'h30, 1'b1, 1'b0);
    apply(16'h8000, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 16'h8000, 6'h15, 1'b0, 1'b0);
    apply(16'h8000, 6'h15, 1'b1, 1'b0, 1'b0, 1'b1, 5'd21, 1'b0, 16'h8000, 6'h35, 1'b1, 1'b0);
    apply(16'h0000, 6'h38, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 16'h0000, 6'h38, 1'b0, 1'b1);
    apply(16'h0000, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd25, 1'b1, 16'h0000, 6'h00, 1'b0, 1'b0);
    apply(16'h0000, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 16'h0000, 6'h25, 1'b1, 1'b0);

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.din = 16'h1234 + 16'(i);
      bus.chk = 6'h2A;
      bus.inj_en = 1'b1;
      bus.inj_pos = 5'd7;
      @(posedge clk);
      #1 check_outputs("hold", last, 1'b0);
    end

    repeat (3) @(posedge clk);
    cmp("pending_results", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/c1908_fo_ecc.md
# c1908_fo_ecc

Registered 16-bit SEC/DED (single-error-correct, double-error-detect) Hamming decoder/encoder, the clocked counterpart of the c1908 benchmark function. It takes a 16-bit data word, 6 received check bits and control/fault-injection inputs, and produces a corrected word, a 6-bit syndrome and error flags one cycle later. Signal ports number 33 in and 25 out, matching the c1908 pin count, plus clock and reset. It sits in testability and benchmark flows as a small, well-defined ECC datapath.

## Interface
No parameters; all widths are fixed.
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- din  in  16  data word d[15:0] (pins in[0..15])
- chk  in  6  received check bits c[5:0]; c[5] = overall parity (in[16..21])
- in_valid  in  1  capture enable (in[22])
- corr_en  in  1  1 = correct single data-bit errors (in[23])
- gen_mode  in  1  1 = encoder mode (in[24])
- odd_par  in  1  1 = odd overall parity convention (in[25])
- inj_en  in  1  fault-injection enable (in[26])
- inj_pos  in  5  codeword index to flip, 0..21 (in[27..31])
- inj_dbl  in  1  also flip index (inj_pos+1) mod 22 (in[32])
- dout  out  16  corrected or raw data (out[0..15])
- syn  out  6  syndrome {s5..s0}, or the generated check bits in gen_mode (out[16..21])
- sec  out  1  single error detected (out[22])
- ded  out  1  double or uncorrectable error (out[23])
- out_valid  out  1  registered in_valid (out[24])

## Operation
- Codeword: index 0 = c[5]; Hamming positions 1..21. Check c[k] (k=0..4) sits at position 2^k. d[0..15] occupy positions 3,5,6,7,9..15,17..21 in ascending order.
- Generated check g[k] = XOR of the data bits whose position has bit k set. g[5] = XOR(d, g[4:0]) XOR odd_par.
- Injection: when inj_en=1, flip codeword index inj_pos before decoding. Index > 21 means no flip. When inj_dbl=1, also flip index (inj_pos+1) mod 22.
- Syndrome: s[4:0] = received c[4:0] XOR the values recomputed from the received data. s5 = XOR of all 22 received bits XOR odd_par.
- Decode:
  - s = 0: no error; sec=0, ded=0.
  - s5=1 and p = s[4:0] ≤ 21: sec=1. If p is a data position and corr_en=1, flip that data bit in dout. A check-bit or index-0 error leaves dout = received data.
  - s5=1 and p > 21: ded=1.
  - s5=0 and s[4:0] ≠ 0: ded=1; dout = received, uncorrected data.
- sec and ded are never both 1.
- gen_mode=1: syn = g[5:0] computed from din with no injection; dout = din; sec=ded=0.

## Timing
- Latency is one cycle. On a rising clk edge with in_valid=1, dout/syn/sec/ded load the combinational results.
- With in_valid=0, dout/syn/sec/ded hold their values.
- out_valid <= in_valid on every edge.
- rst=1 clears all outputs to 0 immediately, independent of clk. Reset asserted mid-stream discards the in-flight result. The first valid output follows one clock edge after a capture made once rst is released.
- Back-to-back in_valid=1 gives one result per cycle; there is no backpressure.

## Test plan
- Reset: assert rst mid-stream -> all outputs 0 at once. Release, apply din=0x0000, chk=0, in_valid=1 -> next cycle dout=0x0000, syn=0, sec=0, ded=0, out_valid=1.
- Single data error: din=0, chk=0, inj_en=1, inj_pos=3, corr_en=1 -> syn=0x23, sec=1, ded=0, dout=0x0000. Same with corr_en=0 -> dout=0x0001.
- Double error: din=0, chk=0, inj_en=1, inj_pos=3, inj_dbl=1 -> syn=0x07, ded=1, sec=0, dout=0x0001.
- Encoder: gen_mode=1, din=0x0001, odd_par=0 -> syn=0x23, dout=0x0001. Feeding din=0x0001 with chk=0x23 in decode mode -> syn=0, no flags.
- Parity-bit error / odd parity: din=0, chk=0x00, odd_par=1 -> sec=1, syn=0x20, dout=0. Index-21 wrap: inj_pos=21, inj_dbl=1 -> flips 21 and 0.
- Hold: in_valid=0 with changing inputs -> dout/syn/sec/ded unchanged; out_valid=0 next cycle.
